// File: rtl/disp_pkg.sv
// Shared types and constants for the two-digit multiplexed display scanner.
package disp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ONES,
    ST_GAP1,
    ST_TENS,
    ST_GAP2
  } scan_state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [1:0] AN_OFF  = 2'b11;

  // Tens digit of a 0..15 value is only ever 0 or 1.
  function automatic logic [3:0] tens_of(input logic [3:0] v);
    return {3'b000, (v >= 4'd10)};
  endfunction

  function automatic logic [3:0] ones_of(input logic [3:0] v);
    return (v >= 4'd10) ? (v - 4'd10) : v;
  endfunction

endpackage

// File: rtl/seg7_enc.sv
// Combinational BCD digit to active-low 7-segment pattern; non-digits blank.
module seg7_enc
  import disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Pattern lookup.
  always_comb begin
    seg = SEG_OFF;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Two-digit multiplexed 7-segment scanner with a one-deep pending slot.
// New values are only committed at the frame boundary so a frame never tears.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int REFRESH_CYCLES = 50000,
  parameter int GAP_CYCLES     = 500,
  parameter int BLANK_LZ       = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_value,
  output logic       in_ready,
  output logic [1:0] an,
  output logic [6:0] seg,
  output logic       frame_tick
);

  localparam int CMAX = (REFRESH_CYCLES > GAP_CYCLES) ? REFRESH_CYCLES : GAP_CYCLES;
  localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;

  scan_state_t state, nxt_state;
  logic [CW-1:0] cnt;
  logic          pend_full;
  logic [3:0]    pend_val;
  logic [3:0]    disp_val, nxt_disp;
  logic          last_cnt, tick, commit, xfer;
  logic [3:0]    digit, nxt_tens;
  logic [6:0]    enc_seg;
  logic [1:0]    nxt_an;
  logic [6:0]    nxt_seg;

  // Phase-end detection, handshake and commit qualification.
  always_comb begin
    if (state == ST_ONES || state == ST_TENS)
      last_cnt = (cnt == CW'(REFRESH_CYCLES - 1));
    else
      last_cnt = (cnt == CW'(GAP_CYCLES - 1));
    tick       = (state == ST_GAP2) && last_cnt;
    commit     = tick && pend_full;
    in_ready   = !rst && (!pend_full || commit);
    xfer       = in_valid && in_ready;
    frame_tick = tick && !rst;
  end

  // Next state and the value that will be on display next cycle.
  always_comb begin
    nxt_state = state;
    unique case (state)
      ST_IDLE: if (xfer)     nxt_state = ST_ONES;
      ST_ONES: if (last_cnt) nxt_state = ST_GAP1;
      ST_GAP1: if (last_cnt) nxt_state = ST_TENS;
      ST_TENS: if (last_cnt) nxt_state = ST_GAP2;
      ST_GAP2: if (last_cnt) nxt_state = ST_ONES;
      default:               nxt_state = ST_IDLE;
    endcase
    if (state == ST_IDLE && xfer) nxt_disp = in_value;
    else if (commit)              nxt_disp = pend_val;
    else                          nxt_disp = disp_val;
  end

  // Digit mux feeding the single encoder, then the enable/segment selection.
  always_comb begin
    nxt_tens = tens_of(nxt_disp);
    digit    = (nxt_state == ST_TENS) ? nxt_tens : ones_of(nxt_disp);
    nxt_an   = AN_OFF;
    nxt_seg  = SEG_OFF;
    if (nxt_state == ST_ONES) begin
      nxt_an  = 2'b10;
      nxt_seg = enc_seg;
    end else if (nxt_state == ST_TENS && !(BLANK_LZ != 0 && nxt_tens == 4'd0)) begin
      nxt_an  = 2'b01;
      nxt_seg = enc_seg;
    end
  end

  seg7_enc u_enc (
    .digit (digit),
    .seg   (enc_seg)
  );

  // State, phase counter, pending slot, display register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pend_full <= 1'b0;
      pend_val  <= '0;
      disp_val  <= '0;
      an        <= AN_OFF;
      seg       <= SEG_OFF;
    end else begin
      state    <= nxt_state;
      cnt      <= (state == ST_IDLE || nxt_state != state) ? '0 : cnt + CW'(1);
      disp_val <= nxt_disp;
      an       <= nxt_an;
      seg      <= nxt_seg;
      if (xfer && state != ST_IDLE) begin
        pend_val  <= in_value;
        pend_full <= 1'b1;
      end else if (commit) begin
        pend_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Randomized bench for disp_scan_ctrl against a frame-position reference model.
module tb_disp_scan_ctrl;

  localparam int RC    = 4;
  localparam int GC    = 2;
  localparam int FRAME = 2 * (RC + GC);

  logic       clk = 1'b0;
  logic       rst, in_valid;
  logic [3:0] in_value;
  logic       in_ready, frame_tick, in_ready0, frame_tick0;
  logic [1:0] an, an0;
  logic [6:0] seg, seg0;

  int n_chk = 0;
  int n_fail = 0;

  // Model: what the display shows during the current cycle.
  bit m_run = 0;
  int m_pos = 0;
  int m_disp = 0;
  bit m_pf = 0;
  int m_pv = 0;
  int cyc = 0;
  int last_tick = -1;

  always #5 clk = ~clk;

  disp_scan_ctrl #(.REFRESH_CYCLES(RC), .GAP_CYCLES(GC), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_value(in_value),
    .in_ready(in_ready), .an(an), .seg(seg), .frame_tick(frame_tick)
  );

  disp_scan_ctrl #(.REFRESH_CYCLES(RC), .GAP_CYCLES(GC), .BLANK_LZ(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_value(in_value),
    .in_ready(in_ready0), .an(an0), .seg(seg0), .frame_tick(frame_tick0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [6:0] pat(input int n);
    case (n)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected {an,seg} for the current model position.
  function automatic logic [8:0] exp_disp(input bit lz);
    int tens;
    tens = m_disp / 10;
    if (!m_run) return {2'b11, 7'h7F};
    if (m_pos < RC) return {2'b10, pat(m_disp % 10)};
    if (m_pos >= RC + GC && m_pos < 2 * RC + GC) begin
      if (lz && tens == 0) return {2'b11, 7'h7F};
      return {2'b01, pat(tens)};
    end
    return {2'b11, 7'h7F};
  endfunction

  // One clock cycle: apply inputs, check at the falling edge, advance the model.
  task automatic step(input bit r, input bit v, input logic [3:0] d);
    bit e_tick, e_commit, e_ready, x;
    rst = r; in_valid = v; in_value = d;
    @(negedge clk);
    e_tick   = !r && m_run && (m_pos == FRAME - 1);
    e_commit = e_tick && m_pf;
    e_ready  = !r && (!m_pf || e_commit);
    chk("in_ready", in_ready, e_ready);
    chk("frame_tick", frame_tick, e_tick);
    chk("an_seg", {an, seg}, exp_disp(1));
    chk("an_seg_nolz", {an0, seg0}, exp_disp(0));
    if (frame_tick === 1'b1) begin
      if (last_tick >= 0) chk("period", cyc - last_tick, FRAME);
      last_tick = cyc;
    end
    if (r) begin
      m_run = 0; m_pos = 0; m_disp = 0; m_pf = 0; last_tick = -1;
    end else begin
      x = v && e_ready;
      if (!m_run) begin
        if (x) begin m_run = 1; m_pos = 0; m_disp = int'(d); end
      end else begin
        if (e_commit) begin m_disp = m_pv; m_pf = 0; end
        if (x) begin m_pv = int'(d); m_pf = 1; end
        m_pos = (m_pos + 1) % FRAME;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 4'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_value = 4'd0;
    @(posedge clk); @(posedge clk); #1;
    // Reset state and idle blank.
    for (int i = 0; i < 3; i++) step(1, 0, 4'd0);
    idle(3);
    // 13 loaded from idle, then 5 offered mid-frame.
    step(0, 1, 4'd13);
    idle(5);
    step(0, 1, 4'd5);
    idle(3);
    step(0, 1, 4'd6);
    idle(2 * FRAME);
    // Hold valid: 9 then 2 across a frame boundary.
    for (int i = 0; i < FRAME + 3; i++) step(0, 1, 4'd9);
    while (m_pos != FRAME - 1) step(0, 1, 4'd9);
    step(0, 1, 4'd9);
    for (int i = 0; i < 3; i++) step(0, 1, 4'd2);
    idle(2 * FRAME);
    // Reset during TENS with a pending value.
    for (int i = 0; i < 2; i++) step(1, 0, 4'd0);
    step(0, 1, 4'd7);
    idle(2);
    step(0, 1, 4'd4);
    while (m_pos != RC + GC + 1) step(0, 0, 4'd0);
    step(1, 0, 4'd0);
    idle(FRAME);
    // 15 displayed across several frames.
    step(0, 1, 4'd15);
    idle(3 * FRAME + 2);
    // Random traffic with occasional reset.
    for (int i = 0; i < 4000; i++) begin
      bit r, v;
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 5) == 0);
      step(r, v, 4'($urandom_range(0, 15)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
